// File: rtl/edit_target_router.sv
// Edit-target selector with per-target command routing and digit_inc auto-repeat.
// Define EDIT_AUTOREPEAT_EN to enable hold-to-repeat on digit_inc.
module edit_target_router #(
  parameter int NUM_TARGETS  = 4,
  parameter int SEL_W        = 2,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   mode_next,
  input  logic                   mode_prev,
  input  logic                   mode_reset,
  input  logic                   is_running,
  input  logic                   digit_change,
  input  logic                   reset_digit,
  input  logic                   reset_value,
  input  logic                   digit_inc,
  output logic [SEL_W-1:0]       display_mode,
  output logic [NUM_TARGETS-1:0] tgt_digitchange,
  output logic [NUM_TARGETS-1:0] tgt_digitinc,
  output logic [NUM_TARGETS-1:0] tgt_digitreset,
  output logic [NUM_TARGETS-1:0] tgt_valuereset,
  output logic                   mode_changed
);

  if (NUM_TARGETS < 2 || NUM_TARGETS > 16 ||
      SEL_W != $clog2(NUM_TARGETS) ||
      REPEAT_DELAY < 2 || REPEAT_RATE < 1) begin : g_bad_param
    $error("edit_target_router: illegal parameters");
  end

  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_TARGETS - 1);
  localparam logic [NUM_TARGETS-1:0] OH0 = NUM_TARGETS'(1);

`ifdef EDIT_AUTOREPEAT_EN
  typedef enum logic [1:0] {
    S_IDLE, S_DELAY, S_REPEAT, S_WAIT_REL
  } state_e;
  localparam int CNT_MAX =
    (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DLY_END = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_END = CNT_W'(REPEAT_RATE - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  typedef enum logic {S_IDLE, S_WAIT_REL} state_e;
`endif

  state_e state_q, state_d;

  logic [SEL_W-1:0]       sel_q, sel_d;
  logic                   mc_q;
  logic [NUM_TARGETS-1:0] dc_q, di_q, dr_q, vr_q;
  logic [NUM_TARGETS-1:0] sel_oh;
  logic                   inc_q;
  logic                   step_v, sel_chg, cmd_ok;
  logic                   inc_rise, inc_fire;

  always_comb begin
    step_v  = !is_running && (mode_next ^ mode_prev);
    sel_chg = mode_reset || step_v;
    cmd_ok  = !is_running && !sel_chg;
    sel_d   = sel_q;
    if (mode_reset) begin
      sel_d = '0;
    end else if (step_v) begin
      if (mode_next) begin
        sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;
      end else begin
        sel_d = (sel_q == '0) ? SEL_MAX : sel_q - 1'b1;
      end
    end
  end

  assign sel_oh       = OH0 << sel_q;
  assign inc_rise     = digit_inc && !inc_q;
  assign display_mode = is_running ? '0 : sel_q;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
`ifdef EDIT_AUTOREPEAT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef EDIT_AUTOREPEAT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
`ifdef EDIT_AUTOREPEAT_EN
    cnt_d   = cnt_q;
`endif
    if (!cmd_ok) begin
      state_d = S_WAIT_REL;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (inc_rise) begin
`ifdef EDIT_AUTOREPEAT_EN
            state_d = S_DELAY;
            cnt_d   = '0;
`else
            state_d = S_WAIT_REL;
`endif
          end
        end
`ifdef EDIT_AUTOREPEAT_EN
        S_DELAY: begin
          if (!digit_inc) begin
            state_d = S_IDLE;
          end else if (cnt_q == DLY_END) begin
            state_d = S_REPEAT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_REPEAT: begin
          if (!digit_inc) begin
            state_d = S_IDLE;
          end else if (cnt_q == RATE_END) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        S_WAIT_REL: begin
          if (!digit_inc) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    inc_fire = 1'b0;
    if (cmd_ok) begin
      unique case (state_q)
        S_IDLE: inc_fire = inc_rise;
`ifdef EDIT_AUTOREPEAT_EN
        S_DELAY:  inc_fire = digit_inc && (cnt_q == DLY_END);
        S_REPEAT: inc_fire = digit_inc && (cnt_q == RATE_END);
`endif
        default: inc_fire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q <= '0;
      mc_q  <= 1'b0;
      inc_q <= 1'b0;
      dc_q  <= '0;
      di_q  <= '0;
      dr_q  <= '0;
      vr_q  <= '0;
    end else begin
      sel_q <= sel_d;
      mc_q  <= (sel_d != sel_q);
      inc_q <= digit_inc;
      dc_q  <= (cmd_ok && digit_change) ? sel_oh : '0;
      di_q  <= inc_fire ? sel_oh : '0;
      dr_q  <= (cmd_ok && reset_digit) ? sel_oh : '0;
      vr_q  <= (cmd_ok && reset_value) ? sel_oh : '0;
    end
  end

  assign mode_changed    = mc_q;
  assign tgt_digitchange = dc_q;
  assign tgt_digitinc    = di_q;
  assign tgt_digitreset  = dr_q;
  assign tgt_valuereset  = vr_q;

endmodule

// File: tb/tb_edit_target_router.sv
// Self-checking bench for edit_target_router (default parameters).
// Honours EDIT_AUTOREPEAT_EN for the auto-repeat expectations.
module tb_edit_target_router;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       mode_next, mode_prev, mode_reset, is_running;
  logic       digit_change, reset_digit, reset_value, digit_inc;
  logic [1:0] display_mode;
  logic [3:0] tgt_digitchange, tgt_digitinc;
  logic [3:0] tgt_digitreset, tgt_valuereset;
  logic       mode_changed;

  edit_target_router dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mode_next       (mode_next),
    .mode_prev       (mode_prev),
    .mode_reset      (mode_reset),
    .is_running      (is_running),
    .digit_change    (digit_change),
    .reset_digit     (reset_digit),
    .reset_value     (reset_value),
    .digit_inc       (digit_inc),
    .display_mode    (display_mode),
    .tgt_digitchange (tgt_digitchange),
    .tgt_digitinc    (tgt_digitinc),
    .tgt_digitreset  (tgt_digitreset),
    .tgt_valuereset  (tgt_valuereset),
    .mode_changed    (mode_changed)
  );

  typedef struct packed {
    logic [1:0] disp;
    logic       mc;
    logic [3:0] dc;
    logic [3:0] di;
    logic [3:0] dr;
    logic [3:0] vr;
  } obs_t;

  typedef struct {
    logic nx, pv, mr, run, dc, rd, rv;
    obs_t exp;
  } vec_t;

  obs_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   esel     = 0;

  function automatic obs_t mk(logic [1:0] d, logic m,
                              logic [3:0] c, logic [3:0] i,
                              logic [3:0] r, logic [3:0] v);
    return {d, m, c, i, r, v};
  endfunction

  function automatic logic [3:0] oh(int s);
    logic [3:0] one = 4'b0001;
    return one << s;
  endfunction

  function automatic bit auto_inc(int k);
    bit r = (k == 0);
`ifdef EDIT_AUTOREPEAT_EN
    if (k >= 16 && ((k - 16) % 4) == 0) r = 1'b1;
`endif
    return r;
  endfunction

  task automatic compare(string name);
    obs_t e, g;
    e = sbq.pop_front();
    g = {display_mode, mode_changed, tgt_digitchange,
         tgt_digitinc, tgt_digitreset, tgt_valuereset};
    n_checks++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got disp=%0d mc=%b dc=%b di=%b dr=%b vr=%b, expected disp=%0d mc=%b dc=%b di=%b dr=%b vr=%b",
               name, g.disp, g.mc, g.dc, g.di, g.dr, g.vr,
               e.disp, e.mc, e.dc, e.di, e.dr, e.vr);
    end
  endtask

  task automatic check_now(string name, obs_t e);
    sbq.push_back(e);
    compare(name);
  endtask

  task automatic step(string name, obs_t e);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    compare(name);
  endtask

  task automatic set_in(logic nx, logic pv, logic mr, logic run,
                        logic dc, logic rd, logic rv, logic inc);
    mode_next    = nx;
    mode_prev    = pv;
    mode_reset   = mr;
    is_running   = run;
    digit_change = dc;
    reset_digit  = rd;
    reset_value  = rv;
    digit_inc    = inc;
  endtask

  vec_t tbl[19];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // nx pv mr run dc rd rv | disp mc dc di dr vr
    tbl[0]  = '{0,0,0,0,0,0,0, mk(0,0,4'h0,4'h0,4'h0,4'h0)};
    tbl[1]  = '{0,0,0,0,1,0,0, mk(0,0,4'h1,4'h0,4'h0,4'h0)};
    tbl[2]  = '{1,0,0,0,0,0,0, mk(1,1,4'h0,4'h0,4'h0,4'h0)};
    tbl[3]  = '{1,0,0,0,1,0,0, mk(2,1,4'h0,4'h0,4'h0,4'h0)};
    tbl[4]  = '{0,0,0,0,0,1,0, mk(2,0,4'h0,4'h0,4'h4,4'h0)};
    tbl[5]  = '{0,0,0,0,1,0,0, mk(2,0,4'h4,4'h0,4'h0,4'h0)};
    tbl[6]  = '{0,0,0,1,1,0,0, mk(0,0,4'h0,4'h0,4'h0,4'h0)};
    tbl[7]  = '{1,0,0,1,0,0,0, mk(0,0,4'h0,4'h0,4'h0,4'h0)};
    tbl[8]  = '{1,1,0,0,0,0,0, mk(2,0,4'h0,4'h0,4'h0,4'h0)};
    tbl[9]  = '{1,0,0,0,0,0,0, mk(3,1,4'h0,4'h0,4'h0,4'h0)};
    tbl[10] = '{1,0,0,0,0,0,0, mk(0,1,4'h0,4'h0,4'h0,4'h0)};
    tbl[11] = '{0,1,0,0,0,0,0, mk(3,1,4'h0,4'h0,4'h0,4'h0)};
    tbl[12] = '{0,0,0,0,0,0,1, mk(3,0,4'h0,4'h0,4'h0,4'h8)};
    tbl[13] = '{0,1,0,0,0,0,0, mk(2,1,4'h0,4'h0,4'h0,4'h0)};
    tbl[14] = '{0,0,1,1,0,0,0, mk(0,1,4'h0,4'h0,4'h0,4'h0)};
    tbl[15] = '{0,0,1,0,0,0,0, mk(0,0,4'h0,4'h0,4'h0,4'h0)};
    tbl[16] = '{0,0,1,0,1,0,0, mk(0,0,4'h0,4'h0,4'h0,4'h0)};
    tbl[17] = '{0,1,0,0,0,0,1, mk(3,1,4'h0,4'h0,4'h0,4'h0)};
    tbl[18] = '{0,0,0,0,1,1,1, mk(3,0,4'h8,4'h0,4'h8,4'h8)};

    reset_n = 1'b0;
    set_in(1, 0, 0, 0, 1, 1, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_state", mk(0,0,4'h0,4'h0,4'h0,4'h0));
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      set_in(tbl[i].nx, tbl[i].pv, tbl[i].mr, tbl[i].run,
             tbl[i].dc, tbl[i].rd, tbl[i].rv, 1'b0);
      step($sformatf("vec%0d", i), tbl[i].exp);
    end
    esel = 3;

    // long hold: single increment, plus auto-repeat when enabled
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 30; k++) begin
      step($sformatf("hold30_k%0d", k),
           mk(2'(esel), 0, 4'h0,
              auto_inc(k) ? oh(esel) : 4'h0, 4'h0, 4'h0));
    end
    digit_inc = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step("hold30_rel", mk(2'(esel),0,4'h0,4'h0,4'h0,4'h0));
    end

    // selection change while held locks out further increments
    digit_inc = 1'b1;
    for (int k = 0; k < 25; k++) begin
      mode_next = (k == 5);
      if (k == 5) esel = (esel + 1) % 4;
      step($sformatf("hold_next_k%0d", k),
           mk(2'(esel), k == 5, 4'h0,
              (k == 0) ? oh(esel) : 4'h0, 4'h0, 4'h0));
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step("next_rel", mk(2'(esel),0,4'h0,4'h0,4'h0,4'h0));
    digit_inc = 1'b1;
    step("repress", mk(2'(esel),0,4'h0,oh(esel),4'h0,4'h0));
    digit_inc = 1'b0;
    step("repress_rel", mk(2'(esel),0,4'h0,4'h0,4'h0,4'h0));

    // hold spanning the end of is_running
    mode_next = 1'b1;
    esel = (esel + 1) % 4;
    step("sel_to_1", mk(2'(esel),1,4'h0,4'h0,4'h0,4'h0));
    set_in(0, 0, 0, 1, 0, 0, 0, 1);
    repeat (5) step("run_hold", mk(0,0,4'h0,4'h0,4'h0,4'h0));
    is_running = 1'b0;
    for (int k = 0; k < 25; k++) begin
      step($sformatf("after_run_k%0d", k),
           mk(2'(esel),0,4'h0,4'h0,4'h0,4'h0));
    end
    digit_inc = 1'b0;
    step("after_run_rel", mk(2'(esel),0,4'h0,4'h0,4'h0,4'h0));
    digit_inc = 1'b1;
    step("after_run_press", mk(2'(esel),0,4'h0,oh(esel),4'h0,4'h0));
    digit_inc = 1'b0;
    step("after_run_idle", mk(2'(esel),0,4'h0,4'h0,4'h0,4'h0));

    // async reset while an increment pulse is on the output
    digit_inc = 1'b1;
`ifdef EDIT_AUTOREPEAT_EN
    for (int k = 0; k <= 16; k++) begin
`else
    for (int k = 0; k <= 0; k++) begin
`endif
      step($sformatf("pre_rst_k%0d", k),
           mk(2'(esel), 0, 4'h0,
              auto_inc(k) ? oh(esel) : 4'h0, 4'h0, 4'h0));
    end
    #1 reset_n = 1'b0;
    #1 check_now("async_reset", mk(0,0,4'h0,4'h0,4'h0,4'h0));
    @(negedge clk);
    reset_n = 1'b1;
    esel = 0;
    step("rst_rel_rise", mk(0,0,4'h0,4'h1,4'h0,4'h0));
    step("rst_rel_hold", mk(0,0,4'h0,4'h0,4'h0,4'h0));
    digit_inc = 1'b0;
    step("rst_rel_idle", mk(0,0,4'h0,4'h0,4'h0,4'h0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
